// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_sequencer                                                            |
// | Owns the PC, drives the instruction-memory address, and registers the     |
// | returned word into a one-entry fetch register for decode.                 |
// | Optional: FETCH_PERF_CNT_EN adds cycle_count / retire_count outputs.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_sequencer #(
  parameter int                INSTR_W  = 9,
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] START_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt,
  input  logic [INSTR_W-1:0] imem_instruction,
  output logic [31:0]        current_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic               busy,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]        cycle_count,
  output logic [31:0]        retire_count,
`endif
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
  logic [INSTR_W-1:0] r_instr, w_instr_nxt;
  logic [ADDR_W-1:0]  r_instr_pc, w_instr_pc_nxt;
  logic               r_valid, w_valid_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_pc       <= START_PC;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = r_valid;
    case (r_state)
      S_IDLE, S_HALT: begin
        w_valid_nxt = 1'b0;
        if (start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = START_PC;
        end
      end
      S_RUN: begin
        // Priority: halt, then branch (flushes wrong path, beats stall), then stall.
        if (halt) begin
          w_state_nxt = S_HALT;
          w_valid_nxt = 1'b0;
        end else if (branch_taken) begin
          w_pc_nxt    = branch_target;
          w_valid_nxt = 1'b0;
        end else if (!stall) begin
          w_instr_nxt    = imem_instruction;
          w_instr_pc_nxt = r_pc;
          w_valid_nxt    = 1'b1;
          w_pc_nxt       = r_pc + ADDR_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pc_nxt    = START_PC;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign current_pc  = {{(32-ADDR_W){1'b0}}, r_pc};
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_cycle_cnt, r_retire_cnt;
  logic        w_start_ok, w_retire;

  assign w_start_ok = start && (r_state != S_RUN);
  assign w_retire   = (r_state == S_RUN) && r_valid && !stall && !branch_taken && !halt;

  // Counters saturate rather than wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
    end else if (w_start_ok) begin
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
    end else begin
      if ((r_state == S_RUN) && (r_cycle_cnt != 32'hFFFF_FFFF))
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_retire && (r_retire_cnt != 32'hFFFF_FFFF))
        r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign cycle_count  = r_cycle_cnt;
  assign retire_count = r_retire_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// Testbench for fetch_sequencer: directed test-plan steps followed by random
// stimulus, all checked against a behavioural reference model.
module tb_fetch_sequencer;

  localparam int INSTR_W = 9;
  localparam int ADDR_W  = 12;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] START_PC = '0;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0, stall = 1'b0, branch_taken = 1'b0, halt = 1'b0;
  logic [ADDR_W-1:0]  branch_target = '0;
  logic [INSTR_W-1:0] imem_instruction;
  logic [31:0]        current_pc;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid, busy, done;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]        cycle_count, retire_count;
`endif

  logic [INSTR_W-1:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = idle, 1 = running, 2 = halted.
  int                 m_mode;
  int                 m_pc;
  logic [INSTR_W-1:0] m_instr;
  int                 m_ipc;
  logic               m_valid;
  longint             m_cyc, m_ret;

  always #5 clk = ~clk;

  assign imem_instruction = mem[current_pc[ADDR_W-1:0]];

  fetch_sequencer #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .START_PC(START_PC)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
    .imem_instruction(imem_instruction), .current_pc(current_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .busy(busy),
`ifdef FETCH_PERF_CNT_EN
    .cycle_count(cycle_count), .retire_count(retire_count),
`endif
    .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = int'(START_PC); m_instr = '0; m_ipc = 0; m_valid = 1'b0;
    m_cyc = 0; m_ret = 0;
  endtask

  task automatic model_edge();
    if (m_mode != 1) begin
      m_valid = 1'b0;
      if (start) begin
        m_mode = 1; m_pc = int'(START_PC); m_cyc = 0; m_ret = 0;
      end
    end else begin
      if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
      if (m_valid && !stall && !branch_taken && !halt && m_ret < 64'hFFFF_FFFF) m_ret++;
      if (halt) begin
        m_mode = 2; m_valid = 1'b0;
      end else if (branch_taken) begin
        m_pc = int'(branch_target); m_valid = 1'b0;
      end else if (!stall) begin
        m_instr = mem[m_pc]; m_ipc = m_pc; m_valid = 1'b1;
        m_pc = (m_pc + 1) % DEPTH;
      end
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ":current_pc"}, current_pc, 32'(m_pc));
    chk({ph, ":instr"}, 32'(instr), 32'(m_instr));
    chk({ph, ":instr_pc"}, 32'(instr_pc), 32'(m_ipc));
    chk({ph, ":instr_valid"}, 32'(instr_valid), 32'(m_valid));
    chk({ph, ":busy"}, 32'(busy), 32'(m_mode == 1));
    chk({ph, ":done"}, 32'(done), 32'(m_mode == 2));
`ifdef FETCH_PERF_CNT_EN
    chk({ph, ":cycle_count"}, cycle_count, 32'(m_cyc));
    chk({ph, ":retire_count"}, retire_count, 32'(m_ret));
`endif
  endtask

  // Apply one cycle of inputs, advance model and DUT, then compare.
  task automatic step(input string ph, input logic st, input logic sl, input logic br,
                      input logic [ADDR_W-1:0] tgt, input logic hl);
    start = st; stall = sl; branch_taken = br; branch_target = tgt; halt = hl;
    model_edge();
    @(posedge clk);
    #1;
    start = 1'b0; stall = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    check_all(ph);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = INSTR_W'($urandom);
    mem[0] = 9'h001; mem[1] = 9'h002; mem[2] = 9'h003; mem[3] = 9'h004;

    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b1;
    @(negedge clk);

    // Start, then sequential fetch of words 0..3.
    step("start", 1, 0, 0, '0, 0);
    for (int i = 0; i < 2; i++) step("fetch", 0, 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) step("stall", 0, 1, 0, '0, 0);
    for (int i = 0; i < 2; i++) step("fetch2", 0, 0, 0, '0, 0);
    chk("seq_instr_004", 32'(instr), 32'h004);

    // Branch together with stall: branch wins, one bubble.
    step("br_stall", 0, 1, 1, 12'h100, 0);
    chk("br_bubble_pc", current_pc, 32'h100);
    step("br_tgt", 0, 0, 0, '0, 0);
    chk("br_tgt_ipc", 32'(instr_pc), 32'h100);

    // Wrap from FFF to 000.
    step("br_wrap", 0, 0, 1, 12'hFFF, 0);
    for (int i = 0; i < 3; i++) step("wrap", 0, 0, 0, '0, 0);
    chk("wrap_ipc", 32'(instr_pc), 32'h001);

    // Halt, idle inputs ignored, restart.
    step("halt", 0, 0, 0, '0, 1);
    step("halted", 0, 1, 1, 12'h055, 1);
    step("restart", 1, 0, 0, '0, 0);
    step("restart1", 0, 0, 0, '0, 0);
    chk("restart_instr", 32'(instr), 32'h001);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0), ADDR_W'($urandom),
           ($urandom_range(0, 39) == 0));

    // Asynchronous reset between edges.
    step("pre_arst", 1, 0, 0, '0, 0);
    step("pre_arst1", 0, 0, 0, '0, 0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    @(negedge clk);
    reset = 1'b1;
    step("no_start", 0, 0, 0, '0, 0);
    step("resume", 1, 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) step("resume_fetch", 0, 0, 0, '0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
